fft8_frame_ctrl: RTL and testbench

Sequencer for `eight_point_fft`. Collects a stream of complex samples into 8-point frames and drives the engine's `write` and `start` strobes. Captures the engine's parallel results and replays them as an indexed output stream. It sits between the sample source and result sink on one side and the 8-point FFT datapath on the other, owning all frame-level handshaking.

---
 rtl/fft8_pkg.sv | 15 +
 rtl/fft8_out_serializer.sv | 59 +++++
 rtl/fft8_frame_ctrl.sv | 102 ++++++++++
 tb/tb_fft8_frame_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft8_pkg.sv
// fft8_pkg: shared constants, FSM state type and bus packing offsets for the fft8 frame controller
package fft8_pkg;
  localparam int N_PTS = 8;
  localparam int DW_DEF = 16;
  localparam int BUS_WORDS = 2 * N_PTS;
  localparam int RE_OFS = 0;
  localparam int IM_OFS = 1;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_WAIT_OB,
    ST_CAPTURE
  } state_e;
endpackage

// File: rtl/fft8_out_serializer.sv
// fft8_out_serializer: holds one captured result frame and replays it as an indexed valid/ready stream
module fft8_out_serializer
  import fft8_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_flush,
  input  logic                    i_load,
  input  logic [BUS_WORDS*DW-1:0] i_data,
  input  logic                    i_m_ready,
  output logic                    o_m_valid,
  output logic [DW-1:0]           o_m_real,
  output logic [DW-1:0]           o_m_imag,
  output logic [2:0]              o_m_index,
  output logic                    o_m_last,
  output logic [15:0]             o_frames_done
);
  logic [DW-1:0] r_re [N_PTS];
  logic [DW-1:0] r_im [N_PTS];
  logic          r_full;
  logic [2:0]    r_idx;
  logic [15:0]   r_frames;
  logic          w_hs;
  assign w_hs = r_full & i_m_ready;
  assign o_m_valid = r_full;
  assign o_m_index = r_idx;
  assign o_m_last = r_idx == 3'd7;
  assign o_m_real = r_re[r_idx];
  assign o_m_imag = r_im[r_idx];
  assign o_frames_done = r_frames;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full <= 1'b0;
      r_idx <= 3'd0;
      r_frames <= 16'd0;
    end else if (i_flush) begin
      r_full <= 1'b0;
      r_idx <= 3'd0;
    end else if (i_load) begin
      r_full <= 1'b1;
    end else if (w_hs) begin
      r_idx <= r_idx + 3'd1;
      if (r_idx == 3'd7) begin
        r_full <= 1'b0;
        r_frames <= r_frames + 16'd1;
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      for (int k = 0; k < N_PTS; k++) begin
        r_re[k] <= i_data[(2*k+RE_OFS)*DW +: DW];
        r_im[k] <= i_data[(2*k+IM_OFS)*DW +: DW];
      end
    end
  end
endmodule

// File: rtl/fft8_frame_ctrl.sv
// fft8_frame_ctrl: frames a sample stream into the 8-point FFT engine and replays its results
module fft8_frame_ctrl
  import fft8_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RUN_CYC = 2
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    flush,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DW-1:0]           s_real,
  input  logic [DW-1:0]           s_imag,
  output logic                    fft_write,
  output logic                    fft_start,
  output logic [BUS_WORDS*DW-1:0] fft_in,
  input  logic                    fft_ready,
  input  logic [BUS_WORDS*DW-1:0] fft_out,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DW-1:0]           m_real,
  output logic [DW-1:0]           m_imag,
  output logic [2:0]              m_index,
  output logic                    m_last,
  output logic                    busy,
  output logic [15:0]             frames_done,
  output logic                    err_no_ready
);
  localparam int RCW = $clog2(RUN_CYC);
  state_e         r_state, w_state_nxt;
  logic [3:0]     r_in_cnt;
  logic [RCW-1:0] r_run_cnt;
  logic           r_fft_write, r_fft_start, r_err;
  logic [DW-1:0]  r_re [N_PTS];
  logic [DW-1:0]  r_im [N_PTS];
  logic           w_accept, w_capture, w_ob_full, w_run_done;
  assign s_ready = ~r_in_cnt[3];
  assign w_accept = s_valid & s_ready & ~flush;
  assign w_capture = (r_state == ST_CAPTURE) & ~flush;
  assign w_run_done = r_run_cnt == RCW'(RUN_CYC - 1);
  assign busy = r_state != ST_IDLE;
  assign fft_write = r_fft_write;
  assign fft_start = r_fft_start;
  assign err_no_ready = r_err;
  assign m_valid = w_ob_full;
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    w_state_nxt = r_in_cnt[3] ? ST_LOAD : ST_IDLE;
      ST_LOAD:    w_state_nxt = ST_RUN;
      ST_RUN:     w_state_nxt = !w_run_done ? ST_RUN : w_ob_full ? ST_WAIT_OB : ST_CAPTURE;
      ST_WAIT_OB: w_state_nxt = w_ob_full ? ST_WAIT_OB : ST_CAPTURE;
      default:    w_state_nxt = ST_IDLE;
    endcase
    if (flush) w_state_nxt = ST_IDLE;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_in_cnt <= 4'd0;
      r_run_cnt <= '0;
      r_fft_write <= 1'b0;
      r_fft_start <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fft_write <= w_state_nxt == ST_LOAD;
      r_fft_start <= w_state_nxt == ST_RUN;
      r_run_cnt <= (r_state == ST_RUN && w_state_nxt == ST_RUN) ? r_run_cnt + RCW'(1) : '0;
      r_in_cnt <= (flush || r_state == ST_LOAD) ? 4'd0 : r_in_cnt + {3'd0, w_accept};
      if (w_capture && !fft_ready) r_err <= 1'b1;
    end
  end
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_re[r_in_cnt[2:0]] <= s_real;
      r_im[r_in_cnt[2:0]] <= s_imag;
    end
  end
  always_comb begin
    fft_in = '0;
    for (int k = 0; k < N_PTS; k++) begin
      fft_in[(2*k+RE_OFS)*DW +: DW] = r_re[k];
      fft_in[(2*k+IM_OFS)*DW +: DW] = r_im[k];
    end
  end
  fft8_out_serializer #(.DW(DW)) u_ser (
    .i_clk        (CLK),
    .i_rst_n      (RST_N),
    .i_flush      (flush),
    .i_load       (w_capture),
    .i_data       (fft_out),
    .i_m_ready    (m_ready),
    .o_m_valid    (w_ob_full),
    .o_m_real     (m_real),
    .o_m_imag     (m_imag),
    .o_m_index    (m_index),
    .o_m_last     (m_last),
    .o_frames_done(frames_done)
  );
endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// tb_fft8_frame_ctrl: table, directed and randomized checks of fft8_frame_ctrl against a frame-level model
module tb_fft8_frame_ctrl;
  import fft8_pkg::*;
  localparam int DW = 16;
  localparam int BW = 2 * N_PTS * DW;
  logic CLK, RST_N, flush, s_valid, s_ready, fft_write, fft_start, fft_ready;
  logic m_valid, m_ready, m_last, busy, err_no_ready;
  logic [DW-1:0] s_real, s_imag, m_real, m_imag;
  logic [BW-1:0] fft_in, fft_out, eng_in;
  logic [2:0] m_index;
  logic [15:0] frames_done;
  typedef struct packed {logic [DW-1:0] re; logic [DW-1:0] im; logic [2:0] idx;} word_t;
  typedef struct packed {logic wr; logic st; logic sr; logic mv; logic bz; logic [2:0] idx;} row_t;
  word_t exp_q[$];
  logic [2*DW-1:0] in_q[$];
  word_t w_pop, w_new;
  logic [DW-1:0] fr [N_PTS];
  logic [DW-1:0] fi [N_PTS];
  logic [DW-1:0] e_re [N_PTS];
  logic [DW-1:0] e_im [N_PTS];
  logic prev_stall;
  logic [2:0] st_idx;
  logic [DW-1:0] st_re, st_im;
  int checks = 0, failures = 0, exp_frames = 0;
  row_t tbl [7];
  fft8_frame_ctrl #(.DW(DW), .RUN_CYC(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .flush(flush), .s_valid(s_valid), .s_ready(s_ready),
    .s_real(s_real), .s_imag(s_imag), .fft_write(fft_write), .fft_start(fft_start),
    .fft_in(fft_in), .fft_ready(fft_ready), .fft_out(fft_out), .m_valid(m_valid),
    .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag), .m_index(m_index),
    .m_last(m_last), .busy(busy), .frames_done(frames_done), .err_no_ready(err_no_ready)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  function automatic logic [DW-1:0] xf_re(input logic [DW-1:0] a [N_PTS], input int k);
    return a[N_PTS-1-k] ^ 16'h5A5A;
  endfunction
  function automatic logic [DW-1:0] xf_im(input logic [DW-1:0] a [N_PTS], input int k);
    return a[k] + DW'(3 * k);
  endfunction
  always @(posedge CLK) if (fft_write) eng_in <= fft_in;
  always_comb begin
    for (int k = 0; k < N_PTS; k++) begin
      e_re[k] = eng_in[(2*k)*DW +: DW];
      e_im[k] = eng_in[(2*k+1)*DW +: DW];
    end
  end
  always_comb begin
    fft_out = '0;
    for (int k = 0; k < N_PTS; k++) begin
      fft_out[(2*k)*DW +: DW] = xf_re(e_re, k);
      fft_out[(2*k+1)*DW +: DW] = xf_im(e_im, k);
    end
  end
  always @(negedge CLK) begin
    if (!RST_N) begin
      in_q.delete();
      exp_q.delete();
      exp_frames = 0;
      prev_stall = 1'b0;
    end else if (flush) begin
      in_q.delete();
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!(m_valid && m_index == st_idx && m_real == st_re && m_imag == st_im)) begin
          failures++;
          $display("FAIL stall_hold actual v=%0b idx=%0d re=%0h required idx=%0d re=%0h", m_valid, m_index, m_real, st_idx, st_re);
        end
      end
      if (s_valid && s_ready) begin
        in_q.push_back({s_real, s_imag});
        if (in_q.size() == N_PTS) begin
          for (int k = 0; k < N_PTS; k++) begin
            fr[k] = in_q[k][2*DW-1:DW];
            fi[k] = in_q[k][DW-1:0];
          end
          for (int k = 0; k < N_PTS; k++) begin
            w_new.re = xf_re(fr, k);
            w_new.im = xf_im(fi, k);
            w_new.idx = 3'(k);
            exp_q.push_back(w_new);
          end
          in_q.delete();
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_unexpected actual idx=%0d re=%0h required no output", m_index, m_real);
        end else begin
          w_pop = exp_q.pop_front();
          if ({m_real, m_imag, m_index, m_last} !== {w_pop.re, w_pop.im, w_pop.idx, w_pop.idx == 3'd7}) begin
            failures++;
            $display("FAIL out_word actual re=%0h im=%0h idx=%0d last=%0b required re=%0h im=%0h idx=%0d", m_real, m_imag, m_index, m_last, w_pop.re, w_pop.im, w_pop.idx);
          end
          if (w_pop.idx == 3'd7) exp_frames++;
        end
      end
      prev_stall = m_valid && !m_ready;
      st_idx = m_index;
      st_re = m_real;
      st_im = m_imag;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im);
    int n;
    s_valid = 1'b1;
    s_real = re;
    s_imag = im;
    n = 0;
    while (!s_ready && n < 80) begin
      step();
      n++;
    end
    if (!s_ready) chk("send_timeout", 32'(s_ready), 32'd1);
    step();
    s_valid = 1'b0;
  endtask
  task automatic wait_valid();
    int n;
    n = 0;
    while (!m_valid && n < 50) begin
      step();
      n++;
    end
    chk("valid_timeout", 32'(m_valid), 32'd1);
  endtask
  task automatic wait_drain();
    int n;
    m_ready = 1'b1;
    n = 0;
    while (!(exp_q.size() == 0 && !m_valid && !busy) && n < 300) begin
      step();
      n++;
    end
    chk("drain_done", 32'(exp_q.size() == 0 && !m_valid && !busy), 32'd1);
    chk("frames_done", 32'(frames_done), 32'(exp_frames[15:0]));
  endtask
  initial begin
    tbl[0] = '{wr:0, st:0, sr:0, mv:0, bz:0, idx:0};
    tbl[1] = '{wr:1, st:0, sr:0, mv:0, bz:1, idx:0};
    tbl[2] = '{wr:0, st:1, sr:1, mv:0, bz:1, idx:0};
    tbl[3] = '{wr:0, st:1, sr:1, mv:0, bz:1, idx:0};
    tbl[4] = '{wr:0, st:0, sr:1, mv:0, bz:1, idx:0};
    tbl[5] = '{wr:0, st:0, sr:1, mv:1, bz:0, idx:0};
    tbl[6] = '{wr:0, st:0, sr:1, mv:1, bz:0, idx:1};
    RST_N = 1'b0;
    flush = 1'b0;
    s_valid = 1'b0;
    s_real = '0;
    s_imag = '0;
    m_ready = 1'b1;
    fft_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_flags", 32'({fft_write, fft_start, m_valid, m_last, busy, err_no_ready, s_ready, m_index}), 32'b0000001_000);
    chk("reset_frames", 32'(frames_done), 32'd0);
    RST_N = 1'b1;
    step();
    for (int k = 0; k < N_PTS; k++) send(DW'(k), DW'(-k));
    chk("fft_in_s2", 32'(fft_in[2*DW +: DW]), 32'h0001);
    chk("fft_in_s3", 32'(fft_in[3*DW +: DW]), 32'hFFFF);
    chk("fft_in_s14", 32'(fft_in[14*DW +: DW]), 32'h0007);
    for (int r = 0; r < 7; r++) begin
      if (r > 0) step();
      chk($sformatf("tbl%0d", r), 32'({fft_write, fft_start, s_ready, m_valid, busy, m_index}), 32'(tbl[r]));
    end
    wait_drain();
    chk("frames_one", 32'(frames_done), 32'd1);
    m_ready = 1'b0;
    for (int k = 0; k < N_PTS; k++) send(DW'($urandom), DW'($urandom));
    for (int c = 0; c < 40; c++) begin
      m_ready = ~m_ready;
      step();
    end
    wait_drain();
    m_ready = 1'b0;
    for (int k = 0; k < 3 * N_PTS; k++) send(DW'($urandom), DW'($urandom));
    repeat (6) step();
    chk("bp_hold", 32'({busy, fft_start, s_ready, m_valid, m_index}), 32'b1001_000);
    chk("bp_queued", 32'(exp_q.size()), 32'd24);
    chk("bp_no_drain", 32'(frames_done), 32'd2);
    wait_drain();
    chk("bp_frames", 32'(frames_done), 32'd5);
    m_ready = 1'b0;
    for (int k = 0; k < N_PTS; k++) send(DW'($urandom), DW'($urandom));
    wait_valid();
    m_ready = 1'b1;
    repeat (3) step();
    m_ready = 1'b0;
    chk("flush_idx3", 32'(m_index), 32'd3);
    for (int k = 0; k < 5; k++) send(DW'($urandom), DW'($urandom));
    flush = 1'b1;
    s_valid = 1'b1;
    step();
    flush = 1'b0;
    s_valid = 1'b0;
    chk("flush_after", 32'({m_valid, s_ready, busy, m_index}), 32'b010_000);
    chk("flush_frames", 32'(frames_done), 32'd5);
    for (int k = 0; k < N_PTS; k++) send(DW'($urandom), DW'($urandom));
    wait_drain();
    for (int c = 0; c < 400; c++) begin
      s_valid = $urandom_range(0, 3) != 0;
      s_real = DW'($urandom);
      s_imag = DW'($urandom);
      m_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 99) == 0;
      step();
    end
    s_valid = 1'b0;
    flush = 1'b0;
    wait_drain();
    chk("err_clear", 32'(err_no_ready), 32'd0);
    fft_ready = 1'b0;
    for (int k = 0; k < N_PTS; k++) send(DW'($urandom), DW'($urandom));
    wait_valid();
    chk("err_set", 32'(err_no_ready), 32'd1);
    fft_ready = 1'b1;
    wait_drain();
    for (int k = 0; k < N_PTS; k++) send(DW'($urandom), DW'($urandom));
    wait_drain();
    chk("err_sticky", 32'(err_no_ready), 32'd1);
    m_ready = 1'b0;
    for (int k = 0; k < N_PTS; k++) send(DW'($urandom), DW'($urandom));
    wait_valid();
    for (int k = 0; k < N_PTS; k++) send(DW'($urandom), DW'($urandom));
    begin
      int n;
      n = 0;
      while (!fft_start && n < 30) begin
        step();
        n++;
      end
    end
    chk("arst_pre", 32'({fft_start, m_valid}), 32'b11);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_now", 32'({fft_start, m_valid, busy, fft_write}), 32'b0000);
    repeat (2) @(posedge CLK);
    #3;
    RST_N = 1'b1;
    step();
    chk("arst_after", 32'({s_ready, m_valid, err_no_ready}), 32'b100);
    chk("arst_frames", 32'(frames_done), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
